// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared byte-pair memory.
// Fetch (read-only) and data (read/write) ports share one memory; one transaction at a time.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_ack,
    output logic [DATA_WIDTH-1:0] ic_data_high,
    output logic [DATA_WIDTH-1:0] ic_data_low,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [DATA_WIDTH-1:0] dc_wdata_high,
    input  logic [DATA_WIDTH-1:0] dc_wdata_low,
    output logic                  dc_ack,
    output logic [DATA_WIDTH-1:0] dc_rdata_high,
    output logic [DATA_WIDTH-1:0] dc_rdata_low,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_write_high,
    output logic [DATA_WIDTH-1:0] mem_data_write_low,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_read_high,
    input  logic [DATA_WIDTH-1:0] mem_data_read_low
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  grant;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata_high;
    logic [DATA_WIDTH-1:0] wdata_low;
    logic                  next_grant_c;

    // Tie goes to the port that did not win last time; 1 selects the data port.
    always_comb begin
        next_grant_c = 1'b0;
        if (ic_req && dc_req) begin
            next_grant_c = ~last_grant;
        end else if (dc_req) begin
            next_grant_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            grant         <= 1'b0;
            last_grant    <= 1'b0;
            addr          <= '0;
            we            <= 1'b0;
            wdata_high    <= '0;
            wdata_low     <= '0;
            ic_ack        <= 1'b0;
            dc_ack        <= 1'b0;
            ic_data_high  <= '0;
            ic_data_low   <= '0;
            dc_rdata_high <= '0;
            dc_rdata_low  <= '0;
        end else begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            if (state == IDLE) begin
                if (ic_req || dc_req) begin
                    state      <= BUSY;
                    cnt        <= CNT_LOAD;
                    grant      <= next_grant_c;
                    last_grant <= next_grant_c;
                    if (next_grant_c) begin
                        addr       <= dc_addr;
                        we         <= dc_we;
                        wdata_high <= dc_wdata_high;
                        wdata_low  <= dc_wdata_low;
                    end else begin
                        addr <= ic_addr;
                        we   <= 1'b0;
                    end
                end
            end else begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    // Final access cycle: memory read data is valid now, ack follows next cycle.
                    state <= IDLE;
                    if (grant) begin
                        dc_ack <= 1'b1;
                        if (!we) begin
                            dc_rdata_high <= mem_data_read_high;
                            dc_rdata_low  <= mem_data_read_low;
                        end
                    end else begin
                        ic_ack       <= 1'b1;
                        ic_data_high <= mem_data_read_high;
                        ic_data_low  <= mem_data_read_low;
                    end
                end
            end
        end
    end

    assign mem_address         = addr;
    assign mem_data_write_high = wdata_high;
    assign mem_data_write_low  = wdata_low;
    // Write strobe lasts only the last access cycle so each write lands exactly once.
    assign mem_we              = (state == BUSY) && (cnt == '0) && we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-pair memory model, main build (LATENCY=2)
// and a LATENCY=1 build sharing the same memory image.
module tb_mem_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned L  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ack;
    logic [DW-1:0] ic_data_high, ic_data_low;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [DW-1:0] dc_wdata_high = '0, dc_wdata_low = '0;
    logic          dc_ack;
    logic [DW-1:0] dc_rdata_high, dc_rdata_low;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write_high, mem_data_write_low;
    logic          mem_we;
    logic [DW-1:0] mem_data_read_high, mem_data_read_low;

    logic          ic_req1 = 1'b0;
    logic [AW-1:0] ic_addr1 = '0;
    logic          ic_ack1, dc_ack1, mem_we1;
    logic [DW-1:0] ic_data_high1, ic_data_low1, dc_rdata_high1, dc_rdata_low1;
    logic [AW-1:0] mem_address1;
    logic [DW-1:0] mem_data_write_high1, mem_data_write_low1;
    logic [DW-1:0] mem_data_read_high1, mem_data_read_low1;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack),
        .ic_data_high(ic_data_high), .ic_data_low(ic_data_low),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata_high(dc_wdata_high), .dc_wdata_low(dc_wdata_low),
        .dc_ack(dc_ack), .dc_rdata_high(dc_rdata_high), .dc_rdata_low(dc_rdata_low),
        .mem_address(mem_address),
        .mem_data_write_high(mem_data_write_high), .mem_data_write_low(mem_data_write_low),
        .mem_we(mem_we),
        .mem_data_read_high(mem_data_read_high), .mem_data_read_low(mem_data_read_low)
    );

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_ack(ic_ack1),
        .ic_data_high(ic_data_high1), .ic_data_low(ic_data_low1),
        .dc_req(1'b0), .dc_we(1'b0), .dc_addr(16'h0000),
        .dc_wdata_high(8'h00), .dc_wdata_low(8'h00),
        .dc_ack(dc_ack1), .dc_rdata_high(dc_rdata_high1), .dc_rdata_low(dc_rdata_low1),
        .mem_address(mem_address1),
        .mem_data_write_high(mem_data_write_high1), .mem_data_write_low(mem_data_write_low1),
        .mem_we(mem_we1),
        .mem_data_read_high(mem_data_read_high1), .mem_data_read_low(mem_data_read_low1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            32'h0000: return 8'h5A;
            32'h0100: return 8'hAB;
            32'h0101: return 8'hCD;
            32'hFFFF: return 8'h77;
            default:  return 8'((i * 7) + 3);
        endcase
    endfunction

    // Memory model: combinational byte-pair read with 16-bit wrap, write on clock edge.
    logic [7:0]  mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        mem_ready = 1'b0;
    logic [15:0] addr_p1, addr1_p1;
    assign addr_p1  = mem_address + 16'd1;
    assign addr1_p1 = mem_address1 + 16'd1;
    assign mem_data_read_high  = mem[mem_address];
    assign mem_data_read_low   = mem[addr_p1];
    assign mem_data_read_high1 = mem[mem_address1];
    assign mem_data_read_low1  = mem[addr1_p1];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_address] <= mem_data_write_high;
            mem[addr_p1]     <= mem_data_write_low;
        end
    end

    function automatic logic [7:0] rd(input logic [15:0] a);
        return ref_mem[a];
    endfunction

    typedef struct {
        logic       we;
        logic [7:0] hi;
        logic [7:0] lo;
        int         cyc;
    } exp_t;

    exp_t ic_q[$];
    exp_t dc_q[$];
    exp_t me;
    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_dc_hi = 8'h00, exp_dc_lo = 8'h00;

    // Scoreboard: every ack pops the oldest expectation of its port.
    always @(negedge clk) begin
        if (ic_ack || dc_ack) begin
            checks++;
            if (ic_ack && dc_ack) begin
                failures++;
                $display("FAIL both_acks cycle=%0d ic_ack=%b dc_ack=%b required at most one", cyc, ic_ack, dc_ack);
            end
        end
        if (ic_ack) begin
            checks++;
            if (ic_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ic_ack cycle=%0d", cyc);
            end else begin
                me = ic_q.pop_front();
                if (cyc !== me.cyc || ic_data_high !== me.hi || ic_data_low !== me.lo) begin
                    failures++;
                    $display("FAIL ic_ack cycle=%0d data=%h/%h required cycle=%0d data=%h/%h",
                             cyc, ic_data_high, ic_data_low, me.cyc, me.hi, me.lo);
                end
            end
        end
        if (dc_ack) begin
            checks++;
            if (dc_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dc_ack cycle=%0d", cyc);
            end else begin
                me = dc_q.pop_front();
                if (!me.we) begin
                    exp_dc_hi = me.hi;
                    exp_dc_lo = me.lo;
                end
                if (cyc !== me.cyc || dc_rdata_high !== exp_dc_hi || dc_rdata_low !== exp_dc_lo) begin
                    failures++;
                    $display("FAIL dc_ack we=%b cycle=%0d rdata=%h/%h required cycle=%0d rdata=%h/%h",
                             me.we, cyc, dc_rdata_high, dc_rdata_low, me.cyc, exp_dc_hi, exp_dc_lo);
                end
            end
        end
    end

    task automatic wait_ic_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ic_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dc_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dc_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_ic(input logic [15:0] a);
        bit ok;
        @(posedge clk); #1;
        ic_req = 1'b1;
        ic_addr = a;
        ic_q.push_back('{we: 1'b0, hi: rd(a), lo: rd(a + 16'd1), cyc: cyc + L + 1});
        wait_ic_ack(ok);
        ic_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ic_timeout addr=%h no ack within 20 cycles", a);
        end
    endtask

    task automatic do_dc(input logic w, input logic [15:0] a, input logic [7:0] hi, input logic [7:0] lo);
        bit ok;
        @(posedge clk); #1;
        dc_req = 1'b1;
        dc_we = w;
        dc_addr = a;
        dc_wdata_high = hi;
        dc_wdata_low = lo;
        if (w) begin
            ref_mem[a] = hi;
            ref_mem[a + 16'd1] = lo;
            dc_q.push_back('{we: 1'b1, hi: hi, lo: lo, cyc: cyc + L + 1});
        end else begin
            dc_q.push_back('{we: 1'b0, hi: rd(a), lo: rd(a + 16'd1), cyc: cyc + L + 1});
        end
        wait_dc_ack(ok);
        dc_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dc_timeout addr=%h no ack within 20 cycles", a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ic_ack !== 1'b0 || dc_ack !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ic_ack=%b dc_ack=%b mem_we=%b required 0/0/0", ic_ack, dc_ack, mem_we);
        end
        checks++;
        if ({ic_data_high, ic_data_low, dc_rdata_high, dc_rdata_low} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h required 0", {ic_data_high, ic_data_low, dc_rdata_high, dc_rdata_low});
        end
        checks++;
        if ({mem_address, mem_data_write_high, mem_data_write_low} !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus got=%h required 0", {mem_address, mem_data_write_high, mem_data_write_low});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_ic(16'h0100);
        @(negedge clk);
        checks++;
        if (ic_ack !== 1'b0 || ic_data_high !== 8'hAB || ic_data_low !== 8'hCD) begin
            failures++;
            $display("FAIL fetch_hold ack=%b data=%h/%h required 0 AB/CD", ic_ack, ic_data_high, ic_data_low);
        end
    endtask

    task automatic test_write_read();
        int nwe = 0, we_cyc = -1, c0;
        logic [15:0] we_addr = '0;
        bit ok = 1'b0;
        do_dc(1'b0, 16'h0100, 8'h00, 8'h00);
        @(posedge clk); #1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0200;
        dc_wdata_high = 8'h12; dc_wdata_low = 8'h34;
        c0 = cyc;
        ref_mem[16'h0200] = 8'h12;
        ref_mem[16'h0201] = 8'h34;
        dc_q.push_back('{we: 1'b1, hi: 8'h12, lo: 8'h34, cyc: c0 + L + 1});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we) begin
                nwe++;
                we_cyc = cyc;
                we_addr = mem_address;
            end
            if (dc_ack) begin
                ok = 1'b1;
                break;
            end
        end
        dc_req = 1'b0;
        checks++;
        if (!ok || nwe != 1 || we_cyc != c0 + L || we_addr !== 16'h0200) begin
            failures++;
            $display("FAIL write_strobe ack=%b count=%0d cycle=%0d addr=%h required 1 1 %0d 0200",
                     ok, nwe, we_cyc - c0, we_addr, L);
        end
        checks++;
        if (mem[16'h0200] !== 8'h12 || mem[16'h0201] !== 8'h34) begin
            failures++;
            $display("FAIL write_mem got=%h/%h required 12/34", mem[16'h0200], mem[16'h0201]);
        end
        do_dc(1'b0, 16'h0200, 8'h00, 8'h00);
    endtask

    task automatic test_round_robin();
        int c0, n_ic = 0, n_dc = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        ic_req = 1'b1; ic_addr = 16'h0300;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0400;
        exp_dc_hi = 8'h00; exp_dc_lo = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        dc_q.push_back('{we: 1'b0, hi: rd(16'h0400), lo: rd(16'h0401), cyc: c0 + 1 * (L + 1)});
        ic_q.push_back('{we: 1'b0, hi: rd(16'h0300), lo: rd(16'h0301), cyc: c0 + 2 * (L + 1)});
        dc_q.push_back('{we: 1'b0, hi: rd(16'h0400), lo: rd(16'h0401), cyc: c0 + 3 * (L + 1)});
        ic_q.push_back('{we: 1'b0, hi: rd(16'h0300), lo: rd(16'h0301), cyc: c0 + 4 * (L + 1)});
        for (int i = 0; i < 40 && (n_ic < 2 || n_dc < 2); i++) begin
            @(negedge clk);
            if (dc_ack) n_dc++;
            if (ic_ack) n_ic++;
            if (n_dc == 2) dc_req = 1'b0;
            if (n_ic == 2) ic_req = 1'b0;
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        checks++;
        if (n_ic != 2 || n_dc != 2) begin
            failures++;
            $display("FAIL rr_count ic=%0d dc=%0d required 2/2", n_ic, n_dc);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(posedge clk); #1;
        ic_req = 1'b1;
        ic_addr = 16'hFFFF;
        ic_q.push_back('{we: 1'b0, hi: rd(16'hFFFF), lo: rd(16'h0000), cyc: cyc + L + 1});
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_address !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_addr got=%h required FFFF", mem_address);
        end
        wait_ic_ack(ok);
        ic_req = 1'b0;
        checks++;
        if (!ok || ic_data_low !== 8'h5A) begin
            failures++;
            $display("FAIL wrap_data ack=%b low=%h required 1 5A", ok, ic_data_low);
        end
    endtask

    task automatic test_reset_mid();
        int nwe = 0;
        @(posedge clk); #1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0500;
        dc_wdata_high = 8'hEE; dc_wdata_low = 8'hDD;
        @(posedge clk); #1;
        reset = 1'b1;
        dc_req = 1'b0;
        exp_dc_hi = 8'h00; exp_dc_lo = 8'h00;
        @(negedge clk);
        if (mem_we) nwe++;
        checks++;
        if ({ic_ack, dc_ack, mem_we} !== 3'b000 ||
            {ic_data_high, ic_data_low, dc_rdata_high, dc_rdata_low} !== 32'h0 ||
            {mem_address, mem_data_write_high, mem_data_write_low} !== 32'h0) begin
            failures++;
            $display("FAIL midreset_outputs acks/we=%b data=%h bus=%h required 0",
                     {ic_ack, dc_ack, mem_we}, {ic_data_high, ic_data_low, dc_rdata_high, dc_rdata_low},
                     {mem_address, mem_data_write_high, mem_data_write_low});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we) nwe++;
        end
        checks++;
        if (nwe != 0 || mem[16'h0500] !== rd(16'h0500) || mem[16'h0501] !== rd(16'h0501)) begin
            failures++;
            $display("FAIL midreset_write we_cycles=%0d mem=%h/%h required 0 %h/%h",
                     nwe, mem[16'h0500], mem[16'h0501], rd(16'h0500), rd(16'h0501));
        end
        do_ic(16'h0100);
    endtask

    task automatic test_latency1();
        logic exp_ack;
        @(posedge clk); #1;
        ic_req1 = 1'b1;
        ic_addr1 = 16'h0100;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            exp_ack = (k == 2 || k == 4 || k == 6);
            checks++;
            if (ic_ack1 !== exp_ack || (exp_ack && (ic_data_high1 !== 8'hAB || ic_data_low1 !== 8'hCD))) begin
                failures++;
                $display("FAIL lat1_ack k=%0d ack=%b data=%h/%h required ack=%b AB/CD",
                         k, ic_ack1, ic_data_high1, ic_data_low1, exp_ack);
            end
            if (k == 6) ic_req1 = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        test_reset();
        test_single_fetch();
        test_write_read();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_latency1();
        repeat (4) @(negedge clk);
        checks++;
        if (ic_q.size() != 0 || dc_q.size() != 0) begin
            failures++;
            $display("FAIL pending_acks ic=%0d dc=%0d required 0/0", ic_q.size(), dc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
